// File: rtl/buzzer_arbiter_if.sv
// ---------------------------------------------------------------------------
// buzzer_arbiter_if
//
// Bundles the player/host signals of the buzz-in arbiter.
//   btn[3:0]   raw player buttons, bit i = player i+1 (asynchronous)
//   sw[31:0]   player switches, sw[8i+7:8i] = player i+1
//   arm        host pulse: open a buzz-in round
//   ack        host pulse: winner consumed
//   armed      high while a round is open
//   win_valid  high while a grant is being presented
//   winner     granted player index (0 = p1 .. 3 = p4)
//   win_sw     switch byte of the winner, captured at grant
//   busy       high whenever the arbiter is not idle
//
// Modports:
//   master  host / player side (drives buttons, switches, arm, ack)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface buzzer_arbiter_if;
    logic [3:0]  btn;
    logic [31:0] sw;
    logic        arm;
    logic        ack;
    logic        armed;
    logic        win_valid;
    logic [1:0]  winner;
    logic [7:0]  win_sw;
    logic        busy;

    modport master (
        output btn, sw, arm, ack,
        input  armed, win_valid, winner, win_sw, busy
    );

    modport slave (
        input  btn, sw, arm, ack,
        output armed, win_valid, winner, win_sw, busy
    );
endinterface

// File: rtl/buzzer_arbiter.sv
// ---------------------------------------------------------------------------
// buzzer_arbiter
//
// Buzz-in arbiter for four player ports. Each raw button is synchronized,
// optionally debounced, and edge-detected. Once the host arms a round, the
// first rising edge wins; simultaneous edges are resolved by a rotating
// priority pointer that moves to the player after the last winner. The
// winner index and its switch byte are latched and held until the host
// acknowledges, after which the arbiter waits for all buttons to be released.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    buzzer_arbiter_if.slave (btn, sw, arm, ack in;
//          armed, win_valid, winner, win_sw, busy out, all registered)
//
// Parameter:
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed before
//                    a debounced level change is accepted (1..255)
//
// Build option:
//   BUZZER_DEBOUNCE_EN  when defined, per-button debounce counters are built;
//                       otherwise the debounced level is simply the
//                       synchronizer output delayed by one more register.
// ---------------------------------------------------------------------------
module buzzer_arbiter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    buzzer_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_GRANT   = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    logic [3:0] sync1_r;
    logic [3:0] sync2_r;
    logic [3:0] db_r;
    logic [3:0] db_q_r;
    logic [3:0] rise_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;
    logic [1:0] grant_idx_s;
    logic       any_rise_s;
    logic       grant_s;
    state_t     state_r;
    state_t     state_nx_s;
    logic [1:0] ptr_r;
    logic       armed_r;
    logic       win_valid_r;
    logic       busy_r;
    logic [1:0] winner_r;
    logic [7:0] win_sw_r;

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= bus.btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef BUZZER_DEBOUNCE_EN
    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [7:0] cnt_r [4];

    // Debounce: a level change is accepted only after DB_LIMIT differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 8'd0;
            end
            db_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= 8'd0;
                end else if (cnt_r[i] + 8'd1 == DB_LIMIT) begin
                    cnt_r[i] <= 8'd0;
                    db_r[i]  <= ~db_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + 8'd1;
                end
            end
        end
    end
`else
    // Without debouncing the level is the synchronizer output, registered once more
    always_ff @(posedge clk) begin
        if (reset) begin
            db_r <= 4'b0000;
        end else begin
            db_r <= sync2_r;
        end
    end
`endif

    // Previous debounced level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q_r <= 4'b0000;
        end else begin
            db_q_r <= db_r;
        end
    end

    assign rise_s     = db_r & ~db_q_r;
    assign any_rise_s = |rise_s;

    // Rotating-priority pick: rotate so bit 0 is the player at ptr, then take
    // the lowest set bit and add the pointer back
    always_comb begin
        rot_s = 4'(({rise_s, rise_s}) >> ptr_r);
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        grant_idx_s = ptr_r + off_s;
    end

    // Next-state logic; presses outside ARMED and out-of-state host pulses fall through
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (any_rise_s) begin
                    state_nx_s = ST_GRANT;
                    grant_s    = 1'b1;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_GRANT: begin
                if (bus.ack) begin
                    state_nx_s = ST_RELEASE;
                end else begin
                    state_nx_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                if (db_r == 4'b0000) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus status flags decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            armed_r     <= (state_nx_s == ST_ARMED);
            win_valid_r <= (state_nx_s == ST_GRANT);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Grant capture: winner, its switch byte and the advanced priority pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            winner_r <= 2'b00;
            win_sw_r <= 8'h00;
            ptr_r    <= 2'd0;
        end else if (grant_s) begin
            winner_r <= grant_idx_s;
            win_sw_r <= bus.sw[{grant_idx_s, 3'b000} +: 8];
            ptr_r    <= grant_idx_s + 2'd1;
        end
    end

    assign bus.armed     = armed_r;
    assign bus.win_valid = win_valid_r;
    assign bus.busy      = busy_r;
    assign bus.winner    = winner_r;
    assign bus.win_sw    = win_sw_r;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buzzer_arbiter
//
// Scoreboard bench for buzzer_arbiter. Each round's expected grant (winner,
// switch byte, grant cycle) is computed from the arbitration rules -- the
// earliest press wins, ties go to the first pressed player at or after the
// priority pointer, and the pointer moves past the winner -- and queued. A
// monitor pops and compares whenever win_valid rises. Directed sections cover
// reset values, glitch rejection, buttons held across arm, GRANT holding,
// the release wait and reset during GRANT; randomized rounds follow.
// ---------------------------------------------------------------------------
module tb_buzzer_arbiter;

    localparam int DB = 8;
`ifdef BUZZER_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [1:0] w;
        logic [7:0] s;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   model_ptr = 0;
    exp_t exp_q[$];
    logic prev_wv = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    buzzer_arbiter_if bif ();

    buzzer_arbiter #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Grant monitor: compares every new grant against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bif.win_valid && !prev_wv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant_winner", 32'(bif.winner), 32'(e.w));
                check("grant_sw", 32'(bif.win_sw), 32'(e.s));
                check("grant_cycle", 32'(cyc), 32'(e.t));
            end
        end
        prev_wv <= bif.win_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        bif.arm = 1'b1;
        tick(1);
        bif.arm = 1'b0;
    endtask

    task automatic pulse_ack();
        bif.ack = 1'b1;
        tick(1);
        bif.ack = 1'b0;
    endtask

    function automatic int model_pick(input logic [3:0] cand);
        for (int k = 0; k < 4; k++) begin
            if (cand[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic queue_grant(input logic [3:0] cand, input logic [31:0] swv,
                               output int w, output logic [7:0] s);
        exp_t e;
        w = model_pick(cand);
        s = swv[8*w +: 8];
        e.w = 2'(w);
        e.s = s;
        e.t = cyc + LAT;
        exp_q.push_back(e);
        model_ptr = (w + 1) % 4;
    endtask

    task automatic wait_grant();
        int got;
        got = 0;
        for (int k = 0; k < LAT + 10 && got == 0; k++) begin
            if (bif.win_valid) got = 1;
            else tick(1);
        end
        check("grant_seen", 32'(got), 32'd1);
    endtask

    // One full round: presses staggered by off[i] cycles (-1 = not pressed)
    task automatic do_round(input bit do_arm, input int off[4], input logic [31:0] swv);
        logic [3:0] cand;
        int         w;
        logic [7:0] s;
        bif.sw = swv;
        if (do_arm) begin
            pulse_arm();
            tick(1);
        end
        cand = 4'b0000;
        for (int i = 0; i < 4; i++) if (off[i] == 0) cand[i] = 1'b1;
        queue_grant(cand, swv, w, s);
        for (int step = 0; step < 3; step++) begin
            for (int i = 0; i < 4; i++) if (off[i] == step) bif.btn[i] = 1'b1;
            tick(1);
        end
        wait_grant();
        // Late press and switch change while granted must not disturb the grant
        bif.btn[3] = 1'b1;
        bif.sw = ~swv;
        tick(3);
        check("hold_valid", 32'(bif.win_valid), 32'd1);
        check("hold_winner", 32'(bif.winner), 32'(w));
        check("hold_sw", 32'(bif.win_sw), 32'(s));
        pulse_ack();
        check("ack_valid", 32'(bif.win_valid), 32'd0);
        check("ack_busy", 32'(bif.busy), 32'd1);
        bif.btn = 4'b0000;
        pulse_arm();
        tick(LAT - 2);
        check("release_busy", 32'(bif.busy), 32'd1);
        tick(1);
        check("idle_busy", 32'(bif.busy), 32'd0);
        check("idle_armed", 32'(bif.armed), 32'd0);
        check("idle_winner", 32'(bif.winner), 32'(w));
        tick(2);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         off[4];
        int         mn;
        int         w;
        logic [7:0] s;
        logic [31:0] swv;

        bif.btn = 4'b0000;
        bif.sw  = 32'h0;
        bif.arm = 1'b0;
        bif.ack = 1'b0;
        reset   = 1'b1;
        tick(3);
        check("rst_armed", 32'(bif.armed), 32'd0);
        check("rst_valid", 32'(bif.win_valid), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_winner", 32'(bif.winner), 32'd0);
        check("rst_sw", 32'(bif.win_sw), 32'd0);
        reset = 1'b0;
        tick(2);

        // Simultaneous 1010 twice: pointer 0 -> p2 wins, pointer 2 -> p4 wins, wraps
        off = '{-1, 0, -1, 0};
        do_round(1'b1, off, $urandom);
        off = '{-1, 0, -1, 0};
        do_round(1'b1, off, $urandom);

        // Single press of p3 with a known switch byte
        off = '{-1, -1, 0, -1};
        do_round(1'b1, off, ($urandom & 32'hFF00_FFFF) | 32'h00A5_0000);

        // Glitch rejection (debounced build) / quiet armed wait; ack ignored in ARMED
        pulse_arm();
        tick(1);
`ifdef BUZZER_DEBOUNCE_EN
        bif.btn[0] = 1'b1;
        tick(DB - 1);
        bif.btn[0] = 1'b0;
`endif
        tick(LAT + 4);
        check("glitch_no_grant", 32'(bif.win_valid), 32'd0);
        check("glitch_armed", 32'(bif.armed), 32'd1);
        pulse_ack();
        tick(1);
        check("ack_in_armed", 32'(bif.armed), 32'd1);
        off = '{0, -1, -1, -1};
        do_round(1'b0, off, $urandom);

        // Button held across arm is ignored until re-pressed
        bif.btn[2] = 1'b1;
        tick(LAT + 2);
        pulse_arm();
        tick(LAT + 4);
        check("held_no_grant", 32'(bif.win_valid), 32'd0);
        check("held_armed", 32'(bif.armed), 32'd1);
        bif.btn[2] = 1'b0;
        tick(LAT + 2);
        check("held_release_armed", 32'(bif.armed), 32'd1);
        off = '{-1, -1, 0, -1};
        do_round(1'b0, off, $urandom);

        // Randomized rounds with staggered presses
        for (int r = 0; r < 12; r++) begin
            mn = 3;
            for (int i = 0; i < 4; i++) begin
                off[i] = int'($urandom_range(0, 3));
                if (off[i] == 3) off[i] = -1;
                else if (off[i] < mn) mn = off[i];
            end
            if (mn == 3) begin
                off[$urandom_range(0, 3)] = 0;
                mn = 0;
            end
            for (int i = 0; i < 4; i++) if (off[i] >= 0) off[i] = off[i] - mn;
            do_round(1'b1, off, $urandom);
        end

        // Reset during GRANT clears everything, including the pointer
        swv = $urandom | 32'h0000_0001;
        bif.sw = swv;
        pulse_arm();
        tick(1);
        queue_grant(4'b0001, swv, w, s);
        bif.btn = 4'b0001;
        tick(1);
        wait_grant();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_ptr = 0;
        check("rstg_valid", 32'(bif.win_valid), 32'd0);
        check("rstg_busy", 32'(bif.busy), 32'd0);
        check("rstg_armed", 32'(bif.armed), 32'd0);
        check("rstg_winner", 32'(bif.winner), 32'd0);
        check("rstg_sw", 32'(bif.win_sw), 32'd0);
        bif.btn = 4'b0000;
        tick(LAT + 2);
        off = '{0, -1, -1, 0};
        do_round(1'b1, off, $urandom);

        tick(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
